// File: rtl/axi_pkg.sv
// Shared AXI read-path types: address/data beat structs, response codes,
// address map and the router's state / slave-select enums.
package axi_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } AddrInfo;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } DataInfo;

  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_DECERR = 2'b11;

  localparam logic [15:0] S0_HI16 = 16'h0000;
  localparam logic [15:0] S1_HI16 = 16'h0001;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_ADDR = 2'd1,
    RD_DATA = 2'd2
  } RdRouteState;

  typedef enum logic [1:0] {
    SEL_S0 = 2'd0,
    SEL_S1 = 2'd1,
    SEL_DS = 2'd2
  } SlvSel;

  // Anything outside the two 64 KiB memory windows goes to the default slave.
  function automatic SlvSel decode_sel(input logic [31:0] addr);
    SlvSel sel;
    if (addr[31:16] == S0_HI16) begin
      sel = SEL_S0;
    end else if (addr[31:16] == S1_HI16) begin
      sel = SEL_S1;
    end else begin
      sel = SEL_DS;
    end
    return sel;
  endfunction

endpackage

// File: rtl/axi_arbiter2.sv
// Two-request arbiter for the read router. AXI_RR_ARB_EN selects round-robin
// (priority flips to the other master on commit); otherwise M1 always wins.
module axi_arbiter2
  import axi_pkg::*;
`ifdef AXI_RR_ARB_EN
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       commit,
  input  logic       commit_idx,
  input  logic [1:0] req,
  output logic [1:0] grant
);

  logic prio_r;  // index of the master that wins a tie

  // Priority pointer: after a completed transaction the other master is favoured.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prio_r <= 1'b0;
    end else if (commit) begin
      prio_r <= ~commit_idx;
    end else begin
      prio_r <= prio_r;
    end
  end

  // Grant decode with the tie broken by the pointer.
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = prio_r ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

`else
(
  input  logic [1:0] req,
  output logic [1:0] grant
);

  // Fixed priority: the data master beats instruction fetch.
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = 2'b10;
      default: grant = 2'b00;
    endcase
  end

`endif
endmodule

// File: rtl/axi_read_router.sv
// Read-channel router: 2 masters -> S0 / S1 / default slave, one transaction
// in flight. Define AXI_RR_ARB_EN for round-robin arbitration (default: M1 wins).
module axi_read_router
  import axi_pkg::*;
#(
  parameter int ID_W  = 4,
  parameter int IDS_W = 8
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  // master 0 (instruction fetch)
  input  logic [ID_W-1:0]   ARID_M0,
  input  AddrInfo           AR_M0,
  input  logic              ARVALID_M0,
  output logic              ARREADY_M0,
  output logic [ID_W-1:0]   RID_M0,
  output DataInfo           R_M0,
  output logic [1:0]        RRESP_M0,
  output logic              RVALID_M0,
  input  logic              RREADY_M0,
  // master 1 (data)
  input  logic [ID_W-1:0]   ARID_M1,
  input  AddrInfo           AR_M1,
  input  logic              ARVALID_M1,
  output logic              ARREADY_M1,
  output logic [ID_W-1:0]   RID_M1,
  output DataInfo           R_M1,
  output logic [1:0]        RRESP_M1,
  output logic              RVALID_M1,
  input  logic              RREADY_M1,
  // slave 0
  output logic [IDS_W-1:0]  ARID_S0,
  output AddrInfo           AR_S0,
  output logic              ARVALID_S0,
  input  logic              ARREADY_S0,
  input  logic [IDS_W-1:0]  RID_S0,
  input  DataInfo           R_S0,
  input  logic [1:0]        RRESP_S0,
  input  logic              RVALID_S0,
  output logic              RREADY_S0,
  // slave 1
  output logic [IDS_W-1:0]  ARID_S1,
  output AddrInfo           AR_S1,
  output logic              ARVALID_S1,
  input  logic              ARREADY_S1,
  input  logic [IDS_W-1:0]  RID_S1,
  input  DataInfo           R_S1,
  input  logic [1:0]        RRESP_S1,
  input  logic              RVALID_S1,
  output logic              RREADY_S1,
  // default slave
  output logic [IDS_W-1:0]  ARID_DS,
  output AddrInfo           AR_DS,
  output logic              ARVALID_DS,
  input  logic              ARREADY_DS,
  input  logic [IDS_W-1:0]  RID_DS,
  input  DataInfo           R_DS,
  input  logic [1:0]        RRESP_DS,
  input  logic              RVALID_DS,
  output logic              RREADY_DS
);

  RdRouteState       state_r, next_state_s;
  AddrInfo           ar_r;
  logic [ID_W-1:0]   arid_r;
  logic              mst_r;
  SlvSel             sel_r;

  logic [1:0]        req_s, grant_s;
  logic              gnt_idx_s, ar_hs_s, last_hs_s, rready_mst_s;
  AddrInfo           ar_gnt_s;
  logic [ID_W-1:0]   arid_gnt_s;
  logic [IDS_W-1:0]  arid_fwd_s;

  logic              arready_sel_s, rvalid_sel_s;
  DataInfo           r_sel_s;
  logic [1:0]        rresp_sel_s;
  logic [IDS_W-1:0]  rid_sel_s;
  logic              unused_rid_s;

  assign req_s      = {ARVALID_M1, ARVALID_M0};
  assign gnt_idx_s  = grant_s[1];
  assign ar_gnt_s   = gnt_idx_s ? AR_M1   : AR_M0;
  assign arid_gnt_s = gnt_idx_s ? ARID_M1 : ARID_M0;
  // Slave-side ID carries the originating master index in its top nibble.
  assign arid_fwd_s = IDS_W'({3'b000, mst_r, arid_r});
  assign ar_hs_s    = (state_r == RD_IDLE) && ARESETn && ((grant_s & req_s) != 2'b00);
  assign rready_mst_s = mst_r ? RREADY_M1 : RREADY_M0;
  assign last_hs_s  = (state_r == RD_DATA) && rvalid_sel_s && rready_mst_s && r_sel_s.last;
  assign unused_rid_s = ^rid_sel_s[IDS_W-1:ID_W];

`ifdef AXI_RR_ARB_EN
  axi_arbiter2 u_arb (
    .clk        (ACLK),
    .rst_n      (ARESETn),
    .commit     (last_hs_s),
    .commit_idx (mst_r),
    .req        (req_s),
    .grant      (grant_s)
  );
`else
  axi_arbiter2 u_arb (
    .req   (req_s),
    .grant (grant_s)
  );
`endif

  // Route the selected slave's handshake/data signals onto common wires.
  always_comb begin
    arready_sel_s = 1'b0;
    rvalid_sel_s  = 1'b0;
    r_sel_s       = '0;
    rresp_sel_s   = 2'b00;
    rid_sel_s     = '0;
    case (sel_r)
      SEL_S0: begin
        arready_sel_s = ARREADY_S0; rvalid_sel_s = RVALID_S0;
        r_sel_s = R_S0; rresp_sel_s = RRESP_S0; rid_sel_s = RID_S0;
      end
      SEL_S1: begin
        arready_sel_s = ARREADY_S1; rvalid_sel_s = RVALID_S1;
        r_sel_s = R_S1; rresp_sel_s = RRESP_S1; rid_sel_s = RID_S1;
      end
      SEL_DS: begin
        arready_sel_s = ARREADY_DS; rvalid_sel_s = RVALID_DS;
        r_sel_s = R_DS; rresp_sel_s = RRESP_DS; rid_sel_s = RID_DS;
      end
      default: begin
        arready_sel_s = 1'b0;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state_r <= RD_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; a transaction ends only on the last-beat handshake.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      RD_IDLE: begin
        if (ar_hs_s) next_state_s = RD_ADDR;
        else         next_state_s = RD_IDLE;
      end
      RD_ADDR: begin
        if (arready_sel_s) next_state_s = RD_DATA;
        else               next_state_s = RD_ADDR;
      end
      RD_DATA: begin
        if (last_hs_s) next_state_s = RD_IDLE;
        else           next_state_s = RD_DATA;
      end
      default: next_state_s = RD_IDLE;
    endcase
  end

  // Capture the accepted request so the slave sees stable AR fields.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      ar_r   <= '0;
      arid_r <= '0;
      mst_r  <= 1'b0;
      sel_r  <= SEL_DS;
    end else if (ar_hs_s) begin
      ar_r   <= ar_gnt_s;
      arid_r <= arid_gnt_s;
      mst_r  <= gnt_idx_s;
      sel_r  <= decode_sel(ar_gnt_s.addr);
    end else begin
      ar_r   <= ar_r;
      arid_r <= arid_r;
      mst_r  <= mst_r;
      sel_r  <= sel_r;
    end
  end

  // Port drive: only the granted master / selected slave ever sees a valid qualifier.
  always_comb begin
    ARREADY_M0 = 1'b0;  ARREADY_M1 = 1'b0;
    RVALID_M0  = 1'b0;  RVALID_M1  = 1'b0;
    R_M0       = '0;    R_M1       = '0;
    RRESP_M0   = 2'b00; RRESP_M1   = 2'b00;
    RID_M0     = '0;    RID_M1     = '0;
    ARVALID_S0 = 1'b0;  ARVALID_S1 = 1'b0;  ARVALID_DS = 1'b0;
    RREADY_S0  = 1'b0;  RREADY_S1  = 1'b0;  RREADY_DS  = 1'b0;
    AR_S0      = ar_r;  AR_S1      = ar_r;  AR_DS      = ar_r;
    ARID_S0    = arid_fwd_s; ARID_S1 = arid_fwd_s; ARID_DS = arid_fwd_s;
    case (state_r)
      RD_IDLE: begin
        ARREADY_M0 = ARESETn & grant_s[0];
        ARREADY_M1 = ARESETn & grant_s[1];
      end
      RD_ADDR: begin
        case (sel_r)
          SEL_S0:  ARVALID_S0 = 1'b1;
          SEL_S1:  ARVALID_S1 = 1'b1;
          SEL_DS:  ARVALID_DS = 1'b1;
          default: ARVALID_DS = 1'b0;
        endcase
      end
      RD_DATA: begin
        if (mst_r) begin
          RVALID_M1 = rvalid_sel_s; R_M1 = r_sel_s;
          RRESP_M1  = rresp_sel_s;  RID_M1 = rid_sel_s[ID_W-1:0];
        end else begin
          RVALID_M0 = rvalid_sel_s; R_M0 = r_sel_s;
          RRESP_M0  = rresp_sel_s;  RID_M0 = rid_sel_s[ID_W-1:0];
        end
        case (sel_r)
          SEL_S0:  RREADY_S0 = rready_mst_s;
          SEL_S1:  RREADY_S1 = rready_mst_s;
          SEL_DS:  RREADY_DS = rready_mst_s;
          default: RREADY_DS = 1'b0;
        endcase
      end
      default: begin
        ARREADY_M0 = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_axi_read_router.sv
// Randomised bench for axi_read_router against a transaction-level reference
// model (per-master request queues, address-map decode, arbitration rule).
module tb_axi_read_router;
  import axi_pkg::*;

  localparam int ID_W  = 4;
  localparam int IDS_W = 8;

  logic ACLK = 1'b0;
  logic ARESETn = 1'b0;
  always #5 ACLK = ~ACLK;

  logic [1:0]       arvalid_m = 2'b00, rready_m = 2'b00;
  logic [ID_W-1:0]  arid_m [2];
  AddrInfo          ar_m   [2];
  logic [1:0]       arready_m, rvalid_m;
  logic [ID_W-1:0]  rid_m  [2];
  DataInfo          r_m    [2];
  logic [1:0]       rresp_m[2];

  logic             s_arready[3], s_rvalid[3];
  logic [IDS_W-1:0] s_rid    [3];
  DataInfo          s_r      [3];
  logic [1:0]       s_rresp  [3];
  logic [2:0]       o_arvalid, o_rready;
  AddrInfo          o_ar     [3];
  logic [IDS_W-1:0] o_arid   [3];

  axi_read_router #(.ID_W(ID_W), .IDS_W(IDS_W)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .ARID_M0(arid_m[0]), .AR_M0(ar_m[0]), .ARVALID_M0(arvalid_m[0]), .ARREADY_M0(arready_m[0]),
    .RID_M0(rid_m[0]), .R_M0(r_m[0]), .RRESP_M0(rresp_m[0]), .RVALID_M0(rvalid_m[0]), .RREADY_M0(rready_m[0]),
    .ARID_M1(arid_m[1]), .AR_M1(ar_m[1]), .ARVALID_M1(arvalid_m[1]), .ARREADY_M1(arready_m[1]),
    .RID_M1(rid_m[1]), .R_M1(r_m[1]), .RRESP_M1(rresp_m[1]), .RVALID_M1(rvalid_m[1]), .RREADY_M1(rready_m[1]),
    .ARID_S0(o_arid[0]), .AR_S0(o_ar[0]), .ARVALID_S0(o_arvalid[0]), .ARREADY_S0(s_arready[0]),
    .RID_S0(s_rid[0]), .R_S0(s_r[0]), .RRESP_S0(s_rresp[0]), .RVALID_S0(s_rvalid[0]), .RREADY_S0(o_rready[0]),
    .ARID_S1(o_arid[1]), .AR_S1(o_ar[1]), .ARVALID_S1(o_arvalid[1]), .ARREADY_S1(s_arready[1]),
    .RID_S1(s_rid[1]), .R_S1(s_r[1]), .RRESP_S1(s_rresp[1]), .RVALID_S1(s_rvalid[1]), .RREADY_S1(o_rready[1]),
    .ARID_DS(o_arid[2]), .AR_DS(o_ar[2]), .ARVALID_DS(o_arvalid[2]), .ARREADY_DS(s_arready[2]),
    .RID_DS(s_rid[2]), .R_DS(s_r[2]), .RRESP_DS(s_rresp[2]), .RVALID_DS(s_rvalid[2]), .RREADY_DS(o_rready[2])
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { logic [ID_W-1:0] id; AddrInfo ar; } req_t;
  typedef struct { DataInfo d; logic [1:0] resp; logic [IDS_W-1:0] rid; } beat_t;

  req_t  mq0[$], mq1[$];
  beat_t bq[$];
  bit    busy = 1'b0, fwd = 1'b0, prio = 1'b0;
  int    cur_m = 0, cur_sl = 0, got_obs = 0;
  req_t  cur;
  int    grant_log[$];

  function automatic int tb_dec(input logic [31:0] a);
    if (a[31:16] == 16'h0000) return 0;
    if (a[31:16] == 16'h0001) return 1;
    return 2;
  endfunction

  function automatic int exp_winner(input bit r0, input bit r1, input bit p);
    if (!r0 && !r1) return -1;
`ifdef AXI_RR_ARB_EN
    if (r0 && r1) return p ? 1 : 0;
`else
    if (r1) return 1;
`endif
    return r0 ? 0 : 1;
  endfunction

  function automatic req_t mk_req(input logic [ID_W-1:0] id, input logic [31:0] addr, input int len);
    req_t r;
    r.id = id; r.ar.addr = addr; r.ar.len = 8'(len); r.ar.size = 3'd2; r.ar.burst = 2'b01;
    return r;
  endfunction

  function automatic req_t rand_req();
    int region = $urandom_range(0, 2);
    logic [15:0] hi;
    hi = (region == 0) ? 16'h0000 : (region == 1) ? 16'h0001 : 16'($urandom_range(2, 65535));
    return mk_req(ID_W'($urandom), {hi, 16'($urandom)}, $urandom_range(0, 7));
  endfunction

  // One clock: drive at negedge, check combinational outputs, advance the model.
  task automatic step();
    int w;
    beat_t b;
    @(negedge ACLK);
    arvalid_m[0] = (mq0.size() > 0);
    arvalid_m[1] = (mq1.size() > 0);
    if (mq0.size() > 0) begin arid_m[0] = mq0[0].id; ar_m[0] = mq0[0].ar; end
    if (mq1.size() > 0) begin arid_m[1] = mq1[0].id; ar_m[1] = mq1[0].ar; end
    rready_m[0] = ($urandom_range(0, 3) != 0);
    rready_m[1] = ($urandom_range(0, 3) != 0);
    for (int s = 0; s < 3; s++) begin
      s_arready[s] = ($urandom_range(0, 2) != 0);
      if (busy && fwd && s == cur_sl) begin
        s_rvalid[s] = (bq.size() > 0) && ($urandom_range(0, 3) != 0);
        if (bq.size() > 0) begin s_r[s] = bq[0].d; s_rresp[s] = bq[0].resp; s_rid[s] = bq[0].rid; end
      end else begin
        s_rvalid[s] = ($urandom_range(0, 3) == 0);
        s_r[s].data = $urandom; s_r[s].last = 1'($urandom);
        s_rresp[s] = 2'($urandom); s_rid[s] = IDS_W'($urandom);
      end
    end
    #1;
    w = exp_winner(arvalid_m[0], arvalid_m[1], prio);
    if (!busy) begin
      check_eq("arready_idle", 64'(arready_m), (w < 0) ? 64'd0 : (64'd1 << w));
      check_eq("arvalid_idle", 64'(o_arvalid), 64'd0);
      check_eq("rvalid_idle",  64'(rvalid_m),  64'd0);
      check_eq("rready_idle",  64'(o_rready),  64'd0);
    end else if (!fwd) begin
      check_eq("arready_addr", 64'(arready_m), 64'd0);
      check_eq("arvalid_sel",  64'(o_arvalid), 64'd1 << cur_sl);
      check_eq("ar_fwd",       64'(o_ar[cur_sl]), 64'(cur.ar));
      check_eq("arid_fwd",     64'(o_arid[cur_sl]), 64'({3'b000, cur_m[0], cur.id}));
      check_eq("rvalid_addr",  64'(rvalid_m),  64'd0);
    end else begin
      check_eq("arready_data", 64'(arready_m), 64'd0);
      check_eq("arvalid_data", 64'(o_arvalid), 64'd0);
      check_eq("rvalid_pass",  64'(rvalid_m),  64'(s_rvalid[cur_sl]) << cur_m);
      check_eq("rready_pass",  64'(o_rready),  64'(rready_m[cur_m]) << cur_sl);
      if (s_rvalid[cur_sl]) begin
        check_eq("r_beat", 64'(r_m[cur_m]),   64'(s_r[cur_sl]));
        check_eq("rid",    64'(rid_m[cur_m]), 64'(cur.id));
        check_eq("rresp",  64'(rresp_m[cur_m]), (cur_sl == 2) ? 64'(RESP_DECERR) : 64'(RESP_OKAY));
      end
    end
    if (!busy) begin
      if (arready_m != 2'b00) grant_log.push_back(int'(arready_m[1]));
      if (w >= 0) begin
        cur = (w == 0) ? mq0.pop_front() : mq1.pop_front();
        cur_m = w; cur_sl = tb_dec(cur.ar.addr);
        busy = 1'b1; fwd = 1'b0; got_obs = 0;
      end
    end else if (!fwd) begin
      if (s_arready[cur_sl]) begin
        fwd = 1'b1;
        for (int i = 0; i <= int'(cur.ar.len); i++) begin
          b.d.data = $urandom; b.d.last = (i == int'(cur.ar.len));
          b.resp = (cur_sl == 2) ? RESP_DECERR : RESP_OKAY;
          b.rid = {3'b000, cur_m[0], cur.id};
          bq.push_back(b);
        end
      end
    end else begin
      if (rvalid_m[cur_m] && rready_m[cur_m]) got_obs++;
      if (s_rvalid[cur_sl] && rready_m[cur_m]) begin
        b = bq.pop_front();
        if (b.d.last) begin
          check_eq("beats", 64'(got_obs), 64'(cur.ar.len) + 64'd1);
          busy = 1'b0;
          prio = ~cur_m[0];
        end
      end
    end
  endtask

  task automatic drain(input int budget);
    int c = 0;
    while ((busy || mq0.size() > 0 || mq1.size() > 0) && c < budget) begin
      step();
      c++;
    end
    check_eq("drain_done", 64'(busy || mq0.size() > 0 || mq1.size() > 0), 64'd0);
  endtask

  task automatic check_quiet(input string tag);
    check_eq({tag, "_arready"}, 64'(arready_m), 64'd0);
    check_eq({tag, "_rvalid"},  64'(rvalid_m),  64'd0);
    check_eq({tag, "_arvalid"}, 64'(o_arvalid), 64'd0);
    check_eq({tag, "_rready"},  64'(o_rready),  64'd0);
  endtask

  logic [3:0] order_s;

  initial begin
    for (int s = 0; s < 3; s++) begin
      s_arready[s] = 1'b0; s_rvalid[s] = 1'b0; s_r[s] = '0; s_rresp[s] = 2'b00; s_rid[s] = '0;
    end
    for (int m = 0; m < 2; m++) begin arid_m[m] = '0; ar_m[m] = '0; end
    repeat (3) @(posedge ACLK);
    #1;
    check_quiet("reset");
    @(negedge ACLK);
    ARESETn = 1'b1;

    // Directed: S0 single beat, default slave DECERR, S1 4-beat burst with gaps.
    mq0.push_back(mk_req(4'h5, 32'h0000_0010, 0));
    drain(200);
    mq0.push_back(mk_req(4'h9, 32'h4000_0000, 0));
    drain(200);
    mq1.push_back(mk_req(4'h3, 32'h0001_0004, 3));
    drain(300);

    // Same-cycle requests from both masters, twice each.
    grant_log.delete();
    mq0.push_back(mk_req(4'h1, 32'h0000_0020, 1));
    mq0.push_back(mk_req(4'h2, 32'h0001_0020, 0));
    mq1.push_back(mk_req(4'h7, 32'h0001_0040, 1));
    mq1.push_back(mk_req(4'h8, 32'h0000_0040, 0));
    drain(400);
    check_eq("arb_count", 64'(grant_log.size()), 64'd4);
    order_s = 4'b0000;
    for (int i = 0; i < 4 && i < grant_log.size(); i++) order_s[3-i] = grant_log[i][0];
`ifdef AXI_RR_ARB_EN
    check_eq("arb_order", 64'(order_s), 64'b0101);
`else
    check_eq("arb_order", 64'(order_s), 64'b1100);
`endif

    // Random traffic from both masters.
    for (int c = 0; c < 2500; c++) begin
      if (mq0.size() < 2 && $urandom_range(0, 5) == 0) mq0.push_back(rand_req());
      if (mq1.size() < 2 && $urandom_range(0, 5) == 0) mq1.push_back(rand_req());
      step();
    end
    drain(2000);

    // Reset while the second beat of a 4-beat burst is pending.
    mq0.push_back(mk_req(4'hC, 32'h0000_0100, 3));
    for (int c = 0; c < 300 && !(busy && fwd && got_obs == 1); c++) step();
    check_eq("rst_setup", 64'(busy && fwd && got_obs == 1), 64'd1);
    @(negedge ACLK);
    ARESETn = 1'b0;
    arvalid_m = 2'b00;
    for (int s = 0; s < 3; s++) s_rvalid[s] = 1'b1;
    @(posedge ACLK);
    #1;
    check_quiet("midrst");
    @(negedge ACLK);
    ARESETn = 1'b1;
    for (int s = 0; s < 3; s++) s_rvalid[s] = 1'b0;
    mq0.delete(); mq1.delete(); bq.delete();
    busy = 1'b0; fwd = 1'b0; prio = 1'b0;
    mq1.push_back(mk_req(4'hA, 32'h0001_0020, 1));
    drain(300);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_read_router.md
# axi_read_router

Read-channel half of the AXI interconnect. Accepts AR requests from two masters (M0 = instruction fetch, M1 = data), arbitrates, decodes the address onto one of two memory slaves or the default slave, and steers the R beats back to the granted master. Only one read transaction is in flight at a time; the default slave receives every unmapped address and answers DECERR.

## Interface
Parameters:
- `ID_W`, default 4: master-side ID width (`AXI_ID_BITS`).
- `IDS_W`, default 8: slave-side ID width (`AXI_IDS_BITS`).

Ports (x ∈ {0,1} for masters; s ∈ {S0,S1,DS} for slaves):
- `ACLK` in 1: the single clock.
- `ARESETn` in 1: synchronous, active-low reset.
- `ARID_Mx` in `ID_W`: request ID from master x.
- `AR_Mx` in `$bits(AddrInfo)`: packed addr/len/size/burst.
- `ARVALID_Mx` in 1 / `ARREADY_Mx` out 1: AR handshake.
- `RID_Mx` out `ID_W`, `R_Mx` out `$bits(DataInfo)`, `RRESP_Mx` out 2: read data to master x.
- `RVALID_Mx` out 1 / `RREADY_Mx` in 1: R handshake.
- `ARID_s` out `IDS_W`: `{x as 4 bits, ARID_Mx}`.
- `AR_s` out `$bits(AddrInfo)`, `ARVALID_s` out 1 / `ARREADY_s` in 1.
- `RID_s` in `IDS_W`, `R_s` in `$bits(DataInfo)`, `RRESP_s` in 2, `RVALID_s` in 1 / `RREADY_s` out 1.

## Operation
- Decode on `addr[31:16]`: 0x0000 → S0, 0x0001 → S1, anything else → DS.
- FSM `IDLE → ADDR → DATA → IDLE`.
- IDLE:
  - Arbiter picks a grant among requesting masters.
  - `ARREADY_Mg` = 1 combinationally for the granted master only.
  - On the handshake: register AR, ARID, the master index and the decoded slave select, then go to ADDR.
- ADDR:
  - `ARVALID_sel` = 1, driven from the registered values. `AR_sel`/`ARID_sel` stay stable.
  - Leave for DATA on `ARREADY_sel`.
- DATA:
  - Combinational pass-through: `RVALID_Mg`=`RVALID_sel`, `R_Mg`=`R_sel`, `RRESP_Mg`=`RRESP_sel`, `RID_Mg`=`RID_sel[ID_W-1:0]`, `RREADY_sel`=`RREADY_Mg`.
  - A beat with `last`=1 and `RVALID&&RREADY` returns the FSM to IDLE and updates the arbiter.
- Non-selected ports:
  - `ARVALID` 0, `RREADY` 0, `RVALID` 0.
  - Data outputs are don't-care but must not be X-propagating into valid qualifiers.
- Burst length is not counted; termination relies solely on `last`.

## Timing
- Reset values: `ARREADY_Mx`=0, `RVALID_Mx`=0, `ARVALID_s`=0, `RREADY_s`=0, FSM=IDLE, arbiter priority=M0.
- Latency:
  - Master AR handshake at cycle t → `ARVALID_s` high at t+1.
  - R beats: zero added latency.
- A new AR is accepted no earlier than the cycle after the last-beat handshake. The IDLE cycle is mandatory.
- `ARREADY_Mx` is never asserted outside IDLE. A master holding ARVALID during DATA waits.
- Simultaneous requests in IDLE: the arbiter resolves them. Exactly one ARREADY is high.
- Slave deasserting RVALID mid-burst: `RVALID_Mg` follows, and the FSM holds DATA.
- ARESETn low in any state: next edge forces IDLE and reset values. In-flight beats are dropped.

## Configuration
- `AXI_RR_ARB_EN` defined: round-robin arbitration. After a completed transaction from Mx, the other master has priority. Pointer resets to M0.
- Not defined: fixed priority, M1 always wins over M0. Priority state is not instantiated.

## Structure
- Shared package `axi_pkg`:
  - `AddrInfo` and `DataInfo` structs.
  - Resp codes (OKAY, DECERR).
  - Address-map constants `S0_HI16`=16'h0000, `S1_HI16`=16'h0001.
  - FSM enum `RdRouteState`.
  - Slave-select enum {SEL_S0, SEL_S1, SEL_DS}.
- Sub-module `axi_arbiter2`: 2-request arbiter with a `commit` input that advances the round-robin pointer. It holds the `AXI_RR_ARB_EN` logic.

## Test plan
- M0 reads addr 0x0000_0010, len 0: `ARVALID_S0` at t+1 with `ARID_S0`=0x0X. One S0 beat returns to M0 with `RID_M0`=ARID_M0 and RRESP OKAY. FSM back to IDLE.
- M1 reads 0x0001_0004, len 3, with S1 inserting RVALID gaps: exactly 4 beats reach M1. `RVALID_M0` stays 0 throughout.
- M0 reads 0x4000_0000: routed to DS, `ARID_DS`={4'h0,ARID}. M0 receives RRESP=DECERR with last=1.
- M0 and M1 request in the same IDLE cycle, twice in a row:
  - `AXI_RR_ARB_EN` on: grants M0 then M1.
  - Macro off: grants M1 both times.
- ARESETn pulled low during DATA beat 2 of a len-3 burst: next cycle all ARREADY/RVALID/ARVALID/RREADY are 0. A fresh M1 request is then served normally.
